// File: rtl/nios2_dbg_scan_pkg.sv
// Shared definitions for the Nios II debug scan master.
//   scan_state_e    : scan sequencer states
//   IR_*            : debug slave instruction register codes
//   DEFAULT_DR_WIDTH: default data register (scan chain) length
//   is_scan_state() : true for the states that run tck
package nios2_dbg_scan_pkg;

  localparam int DEFAULT_DR_WIDTH = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_DONE
  } scan_state_e;

  function automatic logic is_scan_state(input scan_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/nios2_dbg_tck_gen.sv
// Divided scan clock generator.
//   clk, reset : system clock, asynchronous active-high reset
//   en         : run tck; while low the phase is parked and tck held low
//   tck        : registered scan clock, TCK_DIV clk low then TCK_DIV clk high
//   rise_pulse : high on the clk cycle whose closing edge raises tck
//   fall_pulse : high on the clk cycle whose closing edge lowers tck
//                (end of a tck period)
module nios2_dbg_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int PW = $clog2(TCK_DIV) + 1;
  localparam logic [PW-1:0] RISE_AT = PW'(TCK_DIV - 1);
  localparam logic [PW-1:0] FALL_AT = PW'(2 * TCK_DIV - 1);

  logic [PW-1:0] phase;

  assign rise_pulse = en && (phase == RISE_AT);
  assign fall_pulse = en && (phase == FALL_AT);

  // NOTE: sequential state uses <= so every register here samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      tck   <= 1'b0;
    end else if (!en) begin
      phase <= '0;
      tck   <= 1'b0;
    end else if (fall_pulse) begin
      phase <= '0;
      tck   <= 1'b0;
    end else begin
      phase <= phase + 1'b1;
      if (rise_pulse) tck <= 1'b1;
    end
  end

endmodule

// File: rtl/nios2_debug_scan_master.sv
// Host-side virtual-JTAG scan initiator for the Nios II debug slave.
// Accepts {IR, DR} commands and runs UIR, CDR, SDR x DR_WIDTH, UDR with a
// divided tck, returning the DR word captured from tdo.
//   cmd_valid/cmd_ready              : command handshake (ready only in IDLE)
//   cmd_ir, cmd_skip_ir, cmd_dr      : IR code, skip-UIR flag, DR word (LSB first)
//   rsp_valid/rsp_ready, rsp_data    : response handshake and captured word
//   tck, tdi, tdo                    : scan clock and serial data
//   ir_in, vs_uir/cdr/sdr/udr        : IR value and virtual state strobes
//   jtag_rti                         : high in IDLE and DONE
module nios2_debug_scan_master
  import nios2_dbg_scan_pkg::*;
#(
  parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic                cmd_skip_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [1:0]          ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_rti
);

  localparam int BW = $clog2(DR_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH);

  scan_state_e         state;
  logic [DR_WIDTH-1:0] sr;
  logic [BW-1:0]       bit_cnt;
  logic                rise_pulse;
  logic                fall_pulse;

  nios2_dbg_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (is_scan_state(state)),
    .tck       (tck),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // Every state change in a scan state lands on fall_pulse, i.e. together
  // with tck falling, so the strobes never move around a rising tck edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data path (sr, rsp_data) is reset too, not just control,
      // so an aborted scan can never surface stale bits later.
      state     <= ST_IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      tdi       <= 1'b0;
      ir_in     <= IR_OCIMEM;
      vs_uir    <= 1'b0;
      vs_cdr    <= 1'b0;
      vs_sdr    <= 1'b0;
      vs_udr    <= 1'b0;
      jtag_rti  <= 1'b1;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            sr        <= cmd_dr;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            jtag_rti  <= 1'b0;
            if (cmd_skip_ir) begin
              state  <= ST_CDR;
              vs_cdr <= 1'b1;
            end else begin
              ir_in  <= cmd_ir;
              state  <= ST_UIR;
              vs_uir <= 1'b1;
            end
          end
        end

        ST_UIR: begin
          if (fall_pulse) begin
            state  <= ST_CDR;
            vs_uir <= 1'b0;
            vs_cdr <= 1'b1;
          end
        end

        ST_CDR: begin
          if (fall_pulse) begin
            state  <= ST_SDR;
            vs_cdr <= 1'b0;
            vs_sdr <= 1'b1;
            tdi    <= sr[0];
          end
        end

        ST_SDR: begin
          // tdo is sampled on the same edge that raises tck, i.e. before the
          // slave shifts, so we see the bit it presented during the low half.
          if (rise_pulse) begin
            sr      <= {tdo, sr[DR_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end else if (fall_pulse) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= ST_UDR;
              vs_sdr  <= 1'b0;
              vs_udr  <= 1'b1;
              tdi     <= 1'b0;
              bit_cnt <= '0;
            end else begin
              tdi <= sr[0];
            end
          end
        end

        ST_UDR: begin
          if (fall_pulse) begin
            state    <= ST_DONE;
            vs_udr   <= 1'b0;
            jtag_rti <= 1'b1;
            rsp_data <= sr;
          end
        end

        ST_DONE: begin
          // rsp_valid qualifies rsp_data one clk after it is written.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// Self-checking bench for nios2_debug_scan_master. Two lanes: lane 0 runs
// TCK_DIV=2, lane 1 runs TCK_DIV=1. Each lane has a behavioural debug slave
// that loads a programmable word on CDR, shifts on tck rise and latches on UDR.
module tb_nios2_debug_scan_master
  import nios2_dbg_scan_pkg::*;
;

  localparam int DW = 38;

  typedef struct {
    logic [1:0]    ir;
    logic          skip;
    logic [DW-1:0] dr;
    logic [DW-1:0] cdr;
    int            hold;
    int            exp_lat;
    logic [DW-1:0] exp_rsp;
    logic [1:0]    exp_ir;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst         [2];
  logic          cmd_valid   [2];
  logic          cmd_ready   [2];
  logic [1:0]    cmd_ir      [2];
  logic          cmd_skip_ir [2];
  logic [DW-1:0] cmd_dr      [2];
  logic          rsp_valid   [2];
  logic          rsp_ready   [2];
  logic [DW-1:0] rsp_data    [2];
  logic          tck         [2];
  logic          tdi         [2];
  logic [1:0]    ir_in       [2];
  logic          vs_uir      [2];
  logic          vs_cdr      [2];
  logic          vs_sdr      [2];
  logic          vs_udr      [2];
  logic          jtag_rti    [2];

  logic [DW-1:0] cdr_val     [2];
  int            mon_sdr     [2];
  int            mon_uir     [2];
  int            mon_udr     [2];
  logic [1:0]    mon_uir_ir  [2];
  logic [DW-1:0] mon_latched [2];

  logic [1:0]    ir_model    [2];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int DIV = (g == 0) ? 2 : 1;
    logic [DW-1:0] s_sr      = '0;
    logic [DW-1:0] s_latched = '0;
    logic [1:0]    s_uir_ir  = '0;
    int            sdr_rises = 0;
    int            uir_seen  = 0;
    int            udr_seen  = 0;

    nios2_debug_scan_master #(
      .DR_WIDTH(DW),
      .TCK_DIV (DIV)
    ) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_ir     (cmd_ir[g]),
      .cmd_skip_ir(cmd_skip_ir[g]),
      .cmd_dr     (cmd_dr[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_data   (rsp_data[g]),
      .tck        (tck[g]),
      .tdi        (tdi[g]),
      .tdo        (s_sr[0]),
      .ir_in      (ir_in[g]),
      .vs_uir     (vs_uir[g]),
      .vs_cdr     (vs_cdr[g]),
      .vs_sdr     (vs_sdr[g]),
      .vs_udr     (vs_udr[g]),
      .jtag_rti   (jtag_rti[g])
    );

    // Debug slave: acts only on rising tck, as the real virtual-JTAG slave does.
    always @(posedge tck[g]) begin
      if (vs_uir[g]) begin
        uir_seen <= uir_seen + 1;
        s_uir_ir <= ir_in[g];
      end
      if (vs_cdr[g]) s_sr <= cdr_val[g];
      if (vs_sdr[g]) begin
        s_sr      <= {tdi[g], s_sr[DW-1:1]};
        sdr_rises <= sdr_rises + 1;
      end
      if (vs_udr[g]) begin
        udr_seen  <= udr_seen + 1;
        s_latched <= s_sr;
      end
    end

    assign mon_sdr[g]     = sdr_rises;
    assign mon_uir[g]     = uir_seen;
    assign mon_udr[g]     = udr_seen;
    assign mon_uir_ir[g]  = s_uir_ir;
    assign mon_latched[g] = s_latched;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input int g, input string tag);
    string p = $sformatf("L%0d %s ", g, tag);
    check({p, "flags"}, {55'd0, tck[g], tdi[g], vs_uir[g], vs_cdr[g], vs_sdr[g],
                         vs_udr[g], jtag_rti[g], cmd_ready[g], rsp_valid[g]}, 64'b000000110);
    check({p, "rsp_data"}, 64'(rsp_data[g]), 64'd0);
    check({p, "ir_in"}, 64'(ir_in[g]), 64'd0);
  endtask

  task automatic pulse_reset(input int g);
    rst[g] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[g] = 1'b0;
    ir_model[g] = 2'd0;
  endtask

  // One full command: offer, time the response, optionally stall it, then
  // compare against the expected latency, response word and slave view.
  task automatic run_cmd(input int g, input vec_t v);
    string p = $sformatf("L%0d ", g);
    int sdr0 = mon_sdr[g];
    int uir0 = mon_uir[g];
    int udr0 = mon_udr[g];
    int lat = 0;
    int bad_toggle = 0;
    logic prev_tck;
    logic stable_ok = 1'b1;
    logic [DW-1:0] got;

    cdr_val[g]     = v.cdr;
    cmd_ir[g]      = v.ir;
    cmd_skip_ir[g] = v.skip;
    cmd_dr[g]      = v.dr;
    cmd_valid[g]   = 1'b1;
    check({p, "cmd_ready_before_accept"}, 64'(cmd_ready[g]), 64'd1);
    @(posedge clk);
    #1 cmd_valid[g] = 1'b0;
    cmd_ir[g] = ~v.ir;
    cmd_dr[g] = ~v.dr;
    prev_tck = tck[g];
    while (!rsp_valid[g] && lat < 1000) begin
      @(posedge clk);
      #1 lat++;
      if (!jtag_rti[g] && tck[g] == prev_tck) bad_toggle++;
      prev_tck = tck[g];
    end
    check({p, "latency"}, 64'(lat), 64'(v.exp_lat));
    if (g == 1) check({p, "tck_toggle_every_clk"}, 64'(bad_toggle), 64'd0);
    if (!rsp_valid[g]) begin
      pulse_reset(g);
      return;
    end
    got = rsp_data[g];
    repeat (v.hold) begin
      @(posedge clk);
      #1;
      if (rsp_valid[g] !== 1'b1 || rsp_data[g] !== got || cmd_ready[g] !== 1'b0 || tck[g] !== 1'b0)
        stable_ok = 1'b0;
    end
    if (v.hold > 0) check({p, "hold_stable"}, 64'(stable_ok), 64'd1);
    rsp_ready[g] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[g] = 1'b0;
    check({p, "ready_after_handshake"}, {62'd0, cmd_ready[g], rsp_valid[g]}, 64'b10);
    check({p, "rsp_data"}, 64'(got), 64'(v.exp_rsp));
    check({p, "slave_latched"}, 64'(mon_latched[g]), 64'(v.dr));
    check({p, "sdr_rises"}, 64'(mon_sdr[g] - sdr0), 64'(DW));
    check({p, "uir_count"}, 64'(mon_uir[g] - uir0), v.skip ? 64'd0 : 64'd1);
    if (!v.skip) check({p, "ir_at_uir"}, 64'(mon_uir_ir[g]), 64'(v.ir));
    check({p, "ir_in"}, 64'(ir_in[g]), 64'(v.exp_ir));
    check({p, "udr_count"}, 64'(mon_udr[g] - udr0), 64'd1);
    if (!v.skip) ir_model[g] = v.ir;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    vec_t rv;
    logic [63:0] r64;
    int   sdr0, udr0, n;
    logic seen;

    vecs[0] = '{IR_BREAK,     1'b0, 38'h15_1234_5678, 38'h2A_5A5A_A5A5, 0,  165, 38'h2A_5A5A_A5A5, 2'd2};
    vecs[1] = '{IR_TRACECTRL, 1'b1, 38'h3F_FFFF_FFFF, 38'h00_0000_0001, 10, 161, 38'h00_0000_0001, 2'd2};
    vecs[2] = '{IR_TRACEMEM,  1'b0, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 0,  165, 38'h3F_FFFF_FFFF, 2'd1};
    vecs[3] = '{IR_OCIMEM,    1'b1, 38'h20_0000_0001, 38'h20_0000_0000, 3,  161, 38'h20_0000_0000, 2'd1};

    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1;
      cmd_valid[g] = 1'b0;
      cmd_ir[g] = 2'd0;
      cmd_skip_ir[g] = 1'b0;
      cmd_dr[g] = '0;
      rsp_ready[g] = 1'b0;
      cdr_val[g] = '0;
      ir_model[g] = 2'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_idle(0, "after_reset");
    check_idle(1, "after_reset");

    // Table-driven commands on the TCK_DIV=2 lane.
    for (int i = 0; i < 4; i++) run_cmd(0, vecs[i]);

    // Reset while shifting bit 17: everything drops at once, no response.
    cdr_val[0] = 38'h12_3456_789A;
    cmd_ir[0] = IR_BREAK;
    cmd_skip_ir[0] = 1'b0;
    cmd_dr[0] = 38'h0F_0F0F_0F0F;
    sdr0 = mon_sdr[0];
    cmd_valid[0] = 1'b1;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    n = 0;
    while (mon_sdr[0] - sdr0 < 17 && n < 1000) begin
      @(posedge clk);
      #1 n++;
    end
    check("L0 reached_bit17", 64'(mon_sdr[0] - sdr0), 64'd17);
    udr0 = mon_udr[0];
    rst[0] = 1'b1;
    #1;
    check_idle(0, "mid_scan_reset");
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0;
    ir_model[0] = 2'd0;
    seen = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (rsp_valid[0]) seen = 1'b1;
    end
    check("L0 no_rsp_after_reset", 64'(seen), 64'd0);
    check("L0 no_udr_after_reset", 64'(mon_udr[0] - udr0), 64'd0);
    run_cmd(0, '{IR_BREAK, 1'b0, 38'h0A_BCDE_F012, 38'h35_A5A5_5A5A, 0, 165,
                 38'h35_A5A5_5A5A, 2'd2});

    // Random commands on the TCK_DIV=1 lane against the reference model.
    for (int i = 0; i < 8; i++) begin
      rv.ir   = 2'($urandom_range(3));
      rv.skip = 1'($urandom_range(1));
      r64     = {$urandom, $urandom};
      rv.dr   = r64[DW-1:0];
      r64     = {$urandom, $urandom};
      rv.cdr  = r64[DW-1:0];
      rv.hold = (i == 3) ? 4 : 0;
      rv.exp_lat = (DW + 3 - (rv.skip ? 1 : 0)) * 2 * 1 + 1;
      rv.exp_rsp = rv.cdr;
      rv.exp_ir  = rv.skip ? ir_model[1] : rv.ir;
      run_cmd(1, rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios2_debug_scan_master.md
Name: nios2_debug_scan_master

Overview:
Host-side initiator for the Nios II debug slave's 2-bit-IR / 38-bit-DR virtual-JTAG scan interface. It turns a parallel command (IR code plus DR word) into a scan on the slave's virtual JTAG pins: UIR, CDR, SDR×DR_WIDTH, UDR, with a divided tck. It returns the DR word shifted out on tdo. Used for on-chip debug access and for simulation benches driving the debug slave without a real TAP.

Parameters:
DR_WIDTH, 38, scan chain length; the shift register and cmd/rsp data width.
TCK_DIV, 2, clk cycles per tck half-period (≥1); one tck period is 2*TCK_DIV clk.

Ports:
clk  in  1  system clock
reset  in  1  one clock; reset is asynchronous and active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_ir  in  2  IR code to load
cmd_skip_ir  in  1  1 = skip the UIR period; ir_in keeps its value
cmd_dr  in  DR_WIDTH  word to shift in, LSB first
rsp_valid  out  1  scan result available
rsp_ready  in  1  result consumed
rsp_data  out  DR_WIDTH  word captured from tdo
tck  out  1  generated scan clock
tdi  out  1  serial data to slave
tdo  in  1  serial data from slave
ir_in  out  2  IR value presented to slave
vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual state strobes
jtag_rti  out  1  high in IDLE and DONE

Behaviour:
- Reset values: tck=0, tdi=0, ir_in=0, all vs_*=0, jtag_rti=1, cmd_ready=1, rsp_valid=0, rsp_data=0, shift register=0, state IDLE.
- All outputs are registered. tck stays low in IDLE and DONE and toggles only in the scan states.
- States: IDLE, UIR, CDR, SDR, UDR, DONE.
- Each scan state lasts one tck period: a low half of TCK_DIV clk, then a high half of TCK_DIV clk.
- The state's vs_* strobe is high for the whole period. State changes coincide with tck falling, so strobes are stable across the slave's rising-edge sample.
- IDLE: on cmd_valid&&cmd_ready, load sr<=cmd_dr; if !cmd_skip_ir then ir_in<=cmd_ir. Next state is UIR, or CDR if cmd_skip_ir.
- UIR → CDR → SDR.
- SDR lasts DR_WIDTH tck periods. tdi=sr[0] is updated at the start of each low half. On the clk cycle tck rises: sr<={tdo, sr[DR_WIDTH-1:1]}, and a bit counter increments.
- SDR → UDR after the DR_WIDTH-th period; no tck edge occurs beyond the final period.
- UDR → DONE: rsp_data<=sr; rsp_valid=1.
- DONE: hold rsp_valid and rsp_data until rsp_ready, then go to IDLE. cmd_ready rises the cycle after the handshake; there is no same-cycle accept of a new command.
- Latency from the accept edge to rsp_valid high = (DR_WIDTH+3-cmd_skip_ir)*2*TCK_DIV + 1 clk.
- cmd_valid outside IDLE is ignored; cmd_* is sampled only at acceptance.
- Counters: phase counter width clog2(TCK_DIV)+1; bit counter width clog2(DR_WIDTH+1). Both wrap only under state control, never free-running.
- Reset mid-scan: immediate return to reset values; the command is dropped with no response. The slave sees tck stop low with all strobes low.
- Bit order: the LSB of cmd_dr reaches the slave first. The slave's captured sr appears in rsp_data at the same bit positions.

Decomposition:
- Package nios2_dbg_scan_pkg holds:
  - state enum;
  - IR code constants IR_OCIMEM=2'd0, IR_TRACEMEM=2'd1, IR_BREAK=2'd2, IR_TRACECTRL=2'd3;
  - default DR_WIDTH=38.
- Sub-module nios2_dbg_tck_gen: phase counter producing tck, rise_pulse and fall_pulse from an enable; reset holds tck low.

Test Plan:
1. Assert then release reset, idle 20 clk → tck=0, all vs_*=0, jtag_rti=1, cmd_ready=1, rsp_valid=0.
2. Bench slave model (38-bit sr, loads 38'h2A_5A5A_A5A5 on CDR, shifts on tck rise, latches on UDR). Send cmd_ir=2'd2, cmd_dr=38'h15_1234_5678 with TCK_DIV=2 → ir_in=2 during UIR; rsp_valid at clk 165 after accept; rsp_data=38'h2A_5A5A_A5A5; model latched 38'h15_1234_5678; exactly 38 tck rises with vs_sdr=1.
3. Repeat with cmd_skip_ir=1 → vs_uir never asserts, ir_in unchanged, rsp_valid at clk 161.
4. Hold rsp_ready=0 for 10 clk after rsp_valid → rsp_valid/rsp_data stable, cmd_ready=0, tck static low; release → cmd_ready=1 one cycle after the handshake.
5. Assert reset during SDR bit 17 → outputs take reset values in the same cycle, no rsp_valid ever, model's UDR not seen; the next command completes normally.
6. TCK_DIV=1 with random cmd_dr against the loopback model → tck toggles every clk in scan states, rsp_data matches the model's capture, latency (41*2)+1=83 clk.
